// File: rtl/tsc_pkg.sv
// ---------------------------------------------------------------------------
// tsc_pkg
// Shared types and constants for the trigger-surround cache serial receiver.
//   rx_state_e : receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   BYTE_W     : width of one received data byte
//   FLEN_W     : width of the frame byte counter / frame_len output
// ---------------------------------------------------------------------------
package tsc_pkg;

    localparam int BYTE_W = 8;
    localparam int FLEN_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage : tsc_pkg

// File: rtl/tsc_serial_rx_if.sv
// ---------------------------------------------------------------------------
// tsc_serial_rx_if
// Byte readout handshake between the serial receiver and the host.
//   rx_data  : FIFO head byte           (receiver -> host)
//   rx_valid : FIFO non-empty           (receiver -> host)
//   rx_ready : host accepts rx_data     (host -> receiver)
// A byte moves when rx_valid && rx_ready on a rising clk edge.
// Modports: master = receiver side, slave = host side.
// ---------------------------------------------------------------------------
interface tsc_serial_rx_if;
    import tsc_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface : tsc_serial_rx_if

// File: rtl/tsc_byte_fifo.sv
// ---------------------------------------------------------------------------
// tsc_byte_fifo
// Synchronous byte FIFO with synchronous active-high reset.
// Parameters:
//   FIFO_DEPTH : number of entries, power of 2, >= 2
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write request and data (ignored while full unless popping)
//   pop        : read request (ignored while empty)
//   dout       : head entry, forced to 0 while empty
//   full/empty : occupancy flags
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the byte is silently dropped (the caller flags overflow).
// ---------------------------------------------------------------------------
module tsc_byte_fifo
    import tsc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers define
    // validity, and leaving the array reset-free lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule : tsc_byte_fifo

// File: rtl/tsc_serial_rx.sv
// ---------------------------------------------------------------------------
// tsc_serial_rx
// Downstream stage of the trigger-surround cache. Deserialises the cache's
// sd bitstream into bytes, frames each capture between a trd rising edge
// (timestamped with trigtm) and a cd rising edge, and buffers bytes in a
// FIFO read out by the host through a valid/ready handshake.
//
// Byte on the wire: start 0, 8 data bits LSB first, [even parity], stop 1;
// each bit lasts BIT_CYCLES clocks and is sampled mid-bit.
//
// Build option: define TSC_RX_PARITY_EN to expect an even-parity bit between
// the data bits and the stop bit. Undefined: 10-bit bytes, no parity logic.
//
// Parameters:
//   BIT_CYCLES : clocks per serial bit (even, >= 2)
//   FIFO_DEPTH : byte FIFO entries (power of 2)
//   FRAME_MAX  : saturation value of the per-frame byte count
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sd           : serial data, idle high
//   trd, trigtm  : trigger detected / trigger time (valid while trd high)
//   cd           : transfer complete
//   rx           : host readout handshake (rx_data, rx_valid, rx_ready)
//   frame_done   : one-cycle pulse on cd rising edge
//   frame_len    : bytes counted in the closed frame
//   frame_trigtm : trigtm captured at the frame's trd rising edge
//   frame_err    : framing/parity error in the current or last frame
//   overflow     : sticky, a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module tsc_serial_rx
    import tsc_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_MAX  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sd,
    input  logic              trd,
    input  logic              cd,
    input  logic [31:0]       trigtm,
    tsc_serial_rx_if.master   rx,
    output logic              frame_done,
    output logic [FLEN_W-1:0] frame_len,
    output logic [31:0]       frame_trigtm,
    output logic              frame_err,
    output logic              overflow
);

    localparam int                CNT_W    = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BIT_CYCLES);
    localparam logic [FLEN_W-1:0] LEN_MAX  = FLEN_W'(FRAME_MAX);

    // ---------------- input registers and edge detection ----------------
    logic sd_q, sd_qq, trd_q, trd_qq, cd_q, cd_qq;
    logic sd_fall, trd_rise, cd_rise;

    // NOTE: every clocked register uses non-blocking assignment so all
    // flops update together and ordering between blocks cannot matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            // sd resets to its idle level so reset release is not a start.
            sd_q   <= 1'b1;
            sd_qq  <= 1'b1;
            trd_q  <= 1'b0;
            trd_qq <= 1'b0;
            cd_q   <= 1'b0;
            cd_qq  <= 1'b0;
        end else begin
            sd_q   <= sd;
            sd_qq  <= sd_q;
            trd_q  <= trd;
            trd_qq <= trd_q;
            cd_q   <= cd;
            cd_qq  <= cd_q;
        end
    end

    assign sd_fall  = sd_qq & ~sd_q;
    assign trd_rise = trd_q & ~trd_qq;
    assign cd_rise  = cd_q & ~cd_qq;

    // ---------------- byte receiver FSM ----------------
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              push_q, push_d;
    logic              byte_err;
    logic              sample_tick;
`ifdef TSC_RX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    // cnt counts the clock position inside the current bit. The start bit
    // is sampled at its midpoint; every later bit one full bit time after.
    assign sample_tick = (state_q == START) ? (cnt_q == CNT_HALF)
                                            : (cnt_q == CNT_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ONE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
`ifdef TSC_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
`ifdef TSC_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch appears.
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        byte_err  = 1'b0;
`ifdef TSC_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = CNT_ONE;
                if (sd_fall) state_d = START;
            end
            START: begin
                if (sample_tick) begin
                    cnt_d     = CNT_ONE;
                    bit_idx_d = '0;
`ifdef TSC_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                    // A high mid-bit sample means the low was a glitch.
                    state_d   = sd_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_tick) begin
                    cnt_d     = CNT_ONE;
                    shift_d   = {sd_q, shift_q[BYTE_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef TSC_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef TSC_RX_PARITY_EN
            PARITY: begin
                if (sample_tick) begin
                    cnt_d     = CNT_ONE;
                    // Even parity: the parity bit equals the XOR of the data.
                    par_err_d = (^shift_q) != sd_q;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (sample_tick) begin
                    cnt_d   = CNT_ONE;
                    state_d = IDLE;
`ifdef TSC_RX_PARITY_EN
                    if (sd_q && !par_err_q) push_d   = 1'b1;
                    else                    byte_err = 1'b1;
`else
                    if (sd_q) push_d   = 1'b1;
                    else      byte_err = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- byte FIFO ----------------
    logic fifo_full, fifo_empty, fifo_pop;

    assign fifo_pop    = rx.rx_valid && rx.rx_ready;
    assign rx.rx_valid = !fifo_empty;

    // shift_q is stable while push_q is high: the FSM sits in IDLE then.
    tsc_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (fifo_pop),
        .din   (shift_q),
        .dout  (rx.rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- frame bookkeeping ----------------
    logic [FLEN_W-1:0] count_q, count_inc;
    logic              frame_done_q, frame_err_q, overflow_q;
    logic [FLEN_W-1:0] frame_len_q;
    logic [31:0]       frame_trigtm_q;

    // Every completed byte counts, including ones the full FIFO drops.
    assign count_inc = (push_q && (count_q < LEN_MAX)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q        <= '0;
            frame_done_q   <= 1'b0;
            frame_len_q    <= '0;
            frame_trigtm_q <= '0;
            frame_err_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            frame_done_q <= cd_rise;
            // Closing uses count_inc so a byte pushed this cycle is included;
            // opening in the same cycle then restarts the count.
            if (cd_rise) frame_len_q <= count_inc;
            if (trd_rise) begin
                count_q        <= '0;
                frame_trigtm_q <= trigtm;
                frame_err_q    <= 1'b0;
            end else begin
                count_q <= count_inc;
            end
            // An error on the same cycle as a new frame belongs to that frame.
            if (byte_err) frame_err_q <= 1'b1;
            if (push_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

    assign frame_done   = frame_done_q;
    assign frame_len    = frame_len_q;
    assign frame_trigtm = frame_trigtm_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;

endmodule : tsc_serial_rx

// File: tb/tb_tsc_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_tsc_serial_rx
// Bench for tsc_serial_rx. Stimulus tasks serialise bytes onto sd and record
// what the host should see (byte queue) and what each frame close should
// report (frame queue). A monitor on the falling clock edge pops and compares
// whenever a byte is handed over or frame_done pulses.
// Build with TSC_RX_PARITY_EN defined to exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_tsc_serial_rx;
    import tsc_pkg::*;

    localparam int BC = 4;
    localparam int FD = 8;
    localparam int FM = 32;
`ifdef TSC_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              sd, trd, cd;
    logic [31:0]       trigtm;
    logic              frame_done, frame_err, overflow;
    logic [FLEN_W-1:0] frame_len;
    logic [31:0]       frame_trigtm;

    tsc_serial_rx_if rx_if ();

    tsc_serial_rx #(
        .BIT_CYCLES (BC),
        .FIFO_DEPTH (FD),
        .FRAME_MAX  (FM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sd           (sd),
        .trd          (trd),
        .cd           (cd),
        .trigtm       (trigtm),
        .rx           (rx_if),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .frame_trigtm (frame_trigtm),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FLEN_W-1:0] len;
        logic [31:0]       tm;
        logic              err;
    } frame_t;

    logic [7:0] byte_q [$];
    frame_t     frame_q [$];

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model of the frame being collected.
    int         m_count = 0;
    logic [31:0] m_tm   = '0;
    logic       m_err   = 1'b0;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        sd = b;
        tick(BC);
    endtask

    // Serialise one byte; record the expected outcome in the model.
    task automatic send_byte(input logic [7:0] d, input bit bad_stop,
                             input bit bad_par, input bit stored);
        bit good;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ bad_par);
        drive_bit(!bad_stop);
        good = !bad_stop && !(PAR_EN && bad_par);
        if (good) begin
            if (m_count < FM) m_count++;
            if (stored) byte_q.push_back(d);
        end else begin
            m_err = 1'b1;
        end
        // A low stop bit needs an idle high before the next start edge.
        if (bad_stop) drive_bit(1'b1);
    endtask

    task automatic open_frame(input logic [31:0] tm);
        trigtm  = tm;
        trd     = 1'b1;
        m_count = 0;
        m_tm    = tm;
        m_err   = 1'b0;
        tick(3);
    endtask

    task automatic close_frame();
        frame_t f;
        f.len = FLEN_W'(m_count);
        f.tm  = m_tm;
        f.err = m_err;
        frame_q.push_back(f);
        cd = 1'b1;
        tick(3);
        cd  = 1'b0;
        trd = 1'b0;
        tick(3);
    endtask

    // Random host back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) rx_if.rx_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares every handed-over byte and every frame report.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                if (byte_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rx_data: got 0x%0h, expected no byte", rx_if.rx_data);
                end else begin
                    check("rx_data", 32'(rx_if.rx_data), 32'(byte_q.pop_front()));
                end
            end
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL frame_done: got pulse, expected none");
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    check("frame_len",    32'(frame_len), 32'(f.len));
                    check("frame_trigtm", frame_trigtm,   f.tm);
                    check("frame_err",    32'(frame_err), 32'(f.err));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        reset = 1'b1;
        sd = 1'b1; trd = 1'b0; cd = 1'b0; trigtm = '0;
        rx_if.rx_ready = 1'b0;
        tick(3);

        // Reset state.
        check("rst_rx_valid",     32'(rx_if.rx_valid), 32'd0);
        check("rst_rx_data",      32'(rx_if.rx_data),  32'd0);
        check("rst_frame_done",   32'(frame_done),     32'd0);
        check("rst_frame_len",    32'(frame_len),      32'd0);
        check("rst_frame_trigtm", frame_trigtm,        32'd0);
        check("rst_frame_err",    32'(frame_err),      32'd0);
        check("rst_overflow",     32'(overflow),       32'd0);
        reset = 1'b0;
        tick(2);

        // 1: single byte latency, rx_valid two cycles after stop sample.
        send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1_valid_at_push", 32'(rx_if.rx_valid), 32'd0);
        tick(1);
        check("t1_valid_after",   32'(rx_if.rx_valid), 32'd1);
        check("t1_data",          32'(rx_if.rx_data),  32'hA5);
        rx_if.rx_ready = 1'b1;
        tick(3);

        // 2: three-byte frame.
        open_frame(32'h0000_1234);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
        close_frame();
        check("t2_len", 32'(frame_len),   32'd3);
        check("t2_tm",  frame_trigtm,     32'h0000_1234);
        check("t2_err", 32'(frame_err),   32'd0);

        // 3: bad stop bit, error cleared by the next trd rise.
        open_frame($urandom);
        send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        check("t3_err_set", 32'(frame_err), 32'd1);
        send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
        close_frame();
        open_frame($urandom);
        check("t3_err_clear", 32'(frame_err), 32'd0);
        close_frame();

        // 4: FIFO overflow with the host stalled.
        check("t4_ovf_before", 32'(overflow), 32'd0);
        rx_if.rx_ready = 1'b0;
        open_frame($urandom);
        for (int i = 0; i < FD + 1; i++) send_byte(8'($urandom), 1'b0, 1'b0, i < FD);
        tick(2);
        check("t4_overflow", 32'(overflow), 32'd1);
        close_frame();
        check("t4_len", 32'(frame_len), 32'(FD + 1));
        rx_if.rx_ready = 1'b1;
        tick(FD + 4);

        // 5a: one-cycle low glitch on sd produces nothing.
        sd = 1'b0;
        tick(1);
        sd = 1'b1;
        tick(6 * BC);
        check("t5_glitch_valid", 32'(rx_if.rx_valid), 32'd0);
        check("t5_glitch_err",   32'(frame_err),      32'd0);

        // 5b: reset in the middle of a byte.
        rx_if.rx_ready = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b1;
        sd    = 1'b1;
        tick(2);
        reset = 1'b0;
        m_count = 0; m_err = 1'b0; m_tm = '0;
        tick(1);
        check("t5_rst_valid", 32'(rx_if.rx_valid), 32'd0);
        check("t5_rst_ovf",   32'(overflow),       32'd0);
        check("t5_rst_len",   32'(frame_len),      32'd0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
        tick(1);
        check("t5_after_rst_valid", 32'(rx_if.rx_valid), 32'd1);
        check("t5_after_rst_data",  32'(rx_if.rx_data),  32'h3C);
        rx_if.rx_ready = 1'b1;
        tick(3);

`ifdef TSC_RX_PARITY_EN
        // 6: parity mismatch drops the byte, correct parity delivers it.
        send_byte(8'h03, 1'b0, 1'b1, 1'b0);
        check("t6_par_err", 32'(frame_err), 32'd1);
        check("t6_no_push", 32'(rx_if.rx_valid), 32'd0);
        send_byte(8'h03, 1'b0, 1'b0, 1'b1);
        tick(3);
`endif

        // Random: a frame long enough to saturate the count, then a frame
        // with random errors and idle gaps, under random back-pressure.
        rand_ready = 1'b1;
        open_frame($urandom);
        for (int i = 0; i < FM + 2; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
        close_frame();
        check("rand_len_sat", 32'(frame_len), 32'(FM));
        open_frame($urandom);
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom), $urandom_range(0, 5) == 0,
                      $urandom_range(0, 5) == 0, 1'b1);
            tick($urandom_range(0, 10));
        end
        close_frame();

        // Drain and confirm nothing is left outstanding.
        rand_ready = 1'b0;
        #1;
        rx_if.rx_ready = 1'b1;
        waited = 0;
        while ((byte_q.size() != 0 || rx_if.rx_valid) && waited < 200) begin
            tick(1);
            waited++;
        end
        tick(2);
        check("drain_bytes",  32'(byte_q.size()),  32'd0);
        check("drain_frames", 32'(frame_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_tsc_serial_rx
